// File: rtl/range_pkg.sv
// Shared types and constants for the range_finder input stage.
// Pin map of io_in and the frame sequencer state encoding.
package range_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  localparam int DATA_W = 10;
  localparam int START_BIT = 10;
  localparam int STOP_BIT = 11;
  localparam int CNT_W = 8;
endpackage

// File: rtl/button_debouncer.sv
// Synchroniser plus stable-level debouncer for one push-button.
// level follows the pin after DEBOUNCE_CYCLES steady cycles; rise strobes once.
module button_debouncer #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic deb_q, deb_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;

  // Shift the pin in, count mismatching cycles, toggle when stable long enough
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[SYNC_STAGES-1] != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    prev_d = deb_q;
    rise_d = deb_q & ~prev_q;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      deb_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      deb_q <= deb_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign level = deb_q;
  assign rise = rise_q;
endmodule

// File: rtl/range_frame_sequencer.sv
// Input-conditioning stage: sync sample bus, debounce start/stop,
// frame a measurement with go/finish pulses and overrun detection.
module range_frame_sequencer
  import range_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_SAMPLES = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [11:0]       io_in,
  output logic [DATA_W-1:0] data_out,
  output logic              go,
  output logic              finish,
  output logic              busy,
  output logic [7:0]        sample_count,
  output logic              overrun
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] dsync_q, dsync_d;
  logic start_level, start_rise, stop_level, stop_rise;
  logic start_ok, stop_ok;

  seq_state_t state_q, state_d;
  logic go_q, go_d, fin_q, fin_d, busy_q, busy_d, ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  button_debouncer #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start (
    .clk(clock),
    .rst_n(reset_n),
    .pin(io_in[START_BIT]),
    .level(start_level),
    .rise(start_rise)
  );

  button_debouncer #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_stop (
    .clk(clock),
    .rst_n(reset_n),
    .pin(io_in[STOP_BIT]),
    .level(stop_level),
    .rise(stop_rise)
  );

  // A press counts only while its debounced level is still held
  assign start_ok = start_rise & start_level;
  assign stop_ok = stop_rise & stop_level;

  // Sample bus synchroniser shift
  always_comb begin
    dsync_d = {dsync_q[SYNC_STAGES-2:0], io_in[DATA_W-1:0]};
  end

  // Frame FSM: next state, registered pulses, counter and overrun
  always_comb begin
    state_d = state_q;
    go_d = 1'b0;
    fin_d = 1'b0;
    busy_d = 1'b0;
    cnt_d = cnt_q;
    ovr_d = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok && !stop_ok) begin
          state_d = RUN;
          go_d = 1'b1;
          busy_d = 1'b1;
          cnt_d = CNT_W'(1);
          ovr_d = 1'b0;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        cnt_d = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + CNT_W'(1);
        if (stop_ok) begin
          fin_d = 1'b1;
          state_d = DONE;
        end else if (cnt_q >= MAX_CNT - CNT_W'(1)) begin
          fin_d = 1'b1;
          ovr_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dsync_q <= '0;
      state_q <= IDLE;
      go_q <= 1'b0;
      fin_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      dsync_q <= dsync_d;
      state_q <= state_d;
      go_q <= go_d;
      fin_q <= fin_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  assign data_out = dsync_q[SYNC_STAGES-1];
  assign go = go_q;
  assign finish = fin_q;
  assign busy = busy_q;
  assign sample_count = cnt_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_range_frame_sequencer.sv
// Scoreboard bench for range_frame_sequencer.
// Expected go/finish events are queued at stimulus time and popped on output.
module tb_range_frame_sequencer;
  logic clock;
  logic reset_n;
  logic [11:0] io_in;
  logic [9:0] data_out;
  logic go;
  logic finish;
  logic busy;
  logic [7:0] sample_count;
  logic overrun;

  typedef struct {
    bit fin;
    int cyc;
    int cnt;
    bit ovr;
    bit chk_data;
    logic [9:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  ev_t new_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cnt = 0;

  range_frame_sequencer dut (
    .clock(clock),
    .reset_n(reset_n),
    .io_in(io_in),
    .data_out(data_out),
    .go(go),
    .finish(finish),
    .busy(busy),
    .sample_count(sample_count),
    .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n && (go || finish)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event cyc=%0d go=%0b finish=%0b",
                 cyc, go, finish);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (finish !== mon_e.fin || go !== !mon_e.fin) begin
          errors++;
          $display("FAIL ev_kind cyc=%0d go=%0b finish=%0b want_fin=%0b",
                   cyc, go, finish, mon_e.fin);
        end
        checks++;
        if (cyc !== mon_e.cyc) begin
          errors++;
          $display("FAIL ev_cycle got=%0d want=%0d fin=%0b",
                   cyc, mon_e.cyc, mon_e.fin);
        end
        checks++;
        if (sample_count !== mon_e.cnt[7:0]) begin
          errors++;
          $display("FAIL ev_count got=%0d want=%0d", sample_count, mon_e.cnt);
        end
        checks++;
        if (overrun !== mon_e.ovr) begin
          errors++;
          $display("FAIL ev_overrun got=%0b want=%0b", overrun, mon_e.ovr);
        end
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL ev_busy got=%0b want=1", busy);
        end
        if (mon_e.chk_data) begin
          checks++;
          if (data_out !== mon_e.data) begin
            errors++;
            $display("FAIL ev_data got=%h want=%h", data_out, mon_e.data);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input bit fin, input int c, input int n,
                      input bit ovr, input bit cd, input logic [9:0] d);
    new_e.fin = fin;
    new_e.cyc = c;
    new_e.cnt = n;
    new_e.ovr = ovr;
    new_e.chk_data = cd;
    new_e.data = d;
    exp_q.push_back(new_e);
  endtask

  task automatic test_reset;
    int c;
    reset_n = 1'b0;
    io_in = 12'h3FF;
    tick(3);
    checks++;
    if ({go, finish, busy, overrun} !== 4'b0 || sample_count !== 8'd0
        || data_out !== 10'd0) begin
      errors++;
      $display("FAIL reset_state go=%0b fin=%0b busy=%0b ovr=%0b cnt=%0d data=%h want all 0",
               go, finish, busy, overrun, sample_count, data_out);
    end
    io_in = 12'h000;
    reset_n = 1'b1;
    tick(4);
    c = cyc;
    io_in[10] = 1'b1;
    push(1'b0, c + 8, 1, 1'b0, 1'b0, 10'd0);
    tick(10);
    io_in[10] = 1'b0;
    tick(5);
    checks++;
    if (busy !== 1'b1 || sample_count !== 8'd8) begin
      errors++;
      $display("FAIL reset_prerun busy=%0b cnt=%0d want 1/8", busy, sample_count);
    end
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({go, finish, busy, overrun} !== 4'b0 || sample_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_midrun go=%0b fin=%0b busy=%0b ovr=%0b cnt=%0d want all 0",
               go, finish, busy, overrun, sample_count);
    end
    tick(2);
    reset_n = 1'b1;
    tick(15);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_after busy=%0b pending=%0d want 0/0", busy, exp_q.size());
    end
  endtask

  task automatic test_basic;
    int c, s;
    c = cyc;
    io_in[10] = 1'b1;
    push(1'b0, c + 8, 1, 1'b0, 1'b0, 10'd0);
    tick(10);
    io_in[10] = 1'b0;
    tick(10);
    s = cyc;
    io_in[11] = 1'b1;
    push(1'b1, s + 8, s - c + 1, 1'b0, 1'b0, 10'd0);
    last_cnt = s - c + 1;
    tick(10);
    io_in[11] = 1'b0;
    tick(15);
    checks++;
    if (busy !== 1'b0 || sample_count !== 8'(last_cnt) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_end busy=%0b cnt=%0d pending=%0d want 0/%0d/0",
               busy, sample_count, exp_q.size(), last_cnt);
    end
  endtask

  task automatic test_bounce;
    int f, s;
    io_in[10] = 1'b1;
    tick(1);
    io_in[10] = 1'b0;
    tick(1);
    io_in[10] = 1'b1;
    tick(1);
    io_in[10] = 1'b0;
    tick(1);
    f = cyc;
    io_in[10] = 1'b1;
    push(1'b0, f + 8, 1, 1'b0, 1'b0, 10'd0);
    tick(10);
    io_in[10] = 1'b0;
    tick(6);
    s = cyc;
    io_in[11] = 1'b1;
    push(1'b1, s + 8, s - f + 1, 1'b0, 1'b0, 10'd0);
    last_cnt = s - f + 1;
    tick(10);
    io_in[11] = 1'b0;
    tick(15);
    checks++;
    if (sample_count !== 8'(last_cnt) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_end cnt=%0d pending=%0d want %0d/0",
               sample_count, exp_q.size(), last_cnt);
    end
  endtask

  task automatic test_overrun;
    int c, s;
    c = cyc;
    io_in[10] = 1'b1;
    push(1'b0, c + 8, 1, 1'b0, 1'b0, 10'd0);
    push(1'b1, c + 8 + 254, 255, 1'b1, 1'b0, 10'd0);
    tick(10);
    io_in[10] = 1'b0;
    tick(270);
    checks++;
    if (overrun !== 1'b1 || sample_count !== 8'd255 || busy !== 1'b0
        || exp_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_hold ovr=%0b cnt=%0d busy=%0b pending=%0d want 1/255/0/0",
               overrun, sample_count, busy, exp_q.size());
    end
    c = cyc;
    io_in[10] = 1'b1;
    push(1'b0, c + 8, 1, 1'b0, 1'b0, 10'd0);
    tick(10);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got=%0b want=0", overrun);
    end
    io_in[10] = 1'b0;
    tick(2);
    s = cyc;
    io_in[11] = 1'b1;
    push(1'b1, s + 8, s - c + 1, 1'b0, 1'b0, 10'd0);
    last_cnt = s - c + 1;
    tick(10);
    io_in[11] = 1'b0;
    tick(15);
  endtask

  task automatic test_simultaneous;
    int c, s;
    io_in[11:10] = 2'b11;
    tick(12);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_idle_busy got=%0b want=0", busy);
    end
    io_in[11:10] = 2'b00;
    tick(10);
    checks++;
    if (sample_count !== 8'(last_cnt) || busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_idle_hold cnt=%0d busy=%0b want %0d/0",
               sample_count, busy, last_cnt);
    end
    c = cyc;
    io_in[10] = 1'b1;
    push(1'b0, c + 8, 1, 1'b0, 1'b0, 10'd0);
    tick(10);
    io_in[10] = 1'b0;
    tick(6);
    s = cyc;
    io_in[11:10] = 2'b11;
    push(1'b1, s + 8, s - c + 1, 1'b0, 1'b0, 10'd0);
    last_cnt = s - c + 1;
    tick(10);
    io_in[11:10] = 2'b00;
    tick(20);
    checks++;
    if (busy !== 1'b0 || sample_count !== 8'(last_cnt) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_run_end busy=%0b cnt=%0d pending=%0d want 0/%0d/0",
               busy, sample_count, exp_q.size(), last_cnt);
    end
  endtask

  task automatic test_data;
    int c, s;
    io_in[9:0] = 10'h000;
    c = cyc;
    io_in[10] = 1'b1;
    push(1'b0, c + 8, 1, 1'b0, 1'b1, 10'h2A5);
    tick(6);
    io_in[9:0] = 10'h2A5;
    tick(1);
    io_in[9:0] = 10'h15A;
    tick(4);
    io_in[10] = 1'b0;
    tick(3);
    s = cyc;
    io_in[11] = 1'b1;
    push(1'b1, s + 8, s - c + 1, 1'b0, 1'b1, 10'h15A);
    tick(10);
    io_in[11] = 1'b0;
    tick(15);
  endtask

  initial begin
    reset_n = 1'b0;
    io_in = 12'h000;
    test_reset();
    test_basic();
    test_bounce();
    test_overrun();
    test_simultaneous();
    test_data();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
